confreg_sram: RTL and testbench

- Register-file responder on the data-side SRAM-style port: en/wen/addr/wdata in, rdata out one cycle later.
- Sits behind the SoC data address decoder, in parallel with data_ram. The CPU is the initiator; this block is the responder end of the same interface.
- Provides an LED output register, synchronised switch input, a 32-bit timer with compare and interrupt, and a scratch register.

---
 rtl/confreg_sram_pkg.sv | 18 +
 rtl/confreg_sram_byte_merge.sv | 13 +
 rtl/confreg_sram.sv | 127 ++++++++++++
 tb/tb_confreg_sram.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/confreg_sram_pkg.sv
// Shared constants for the confreg register block: register offsets,
// CTRL bit positions and the COMPARE reset value.
package confreg_sram_pkg;

  localparam logic [31:0] LED_OFF     = 32'h00;
  localparam logic [31:0] SW_OFF      = 32'h04;
  localparam logic [31:0] TIMER_OFF   = 32'h08;
  localparam logic [31:0] CMP_OFF     = 32'h0C;
  localparam logic [31:0] CTRL_OFF    = 32'h10;
  localparam logic [31:0] SCRATCH_OFF = 32'h14;

  localparam int CTRL_TEN_BIT  = 0;
  localparam int CTRL_IEN_BIT  = 1;
  localparam int CTRL_PEND_BIT = 8;

  localparam logic [31:0] CMP_RST = 32'hFFFF_FFFF;

endpackage

// File: rtl/confreg_sram_byte_merge.sv
// Byte-lane write merge: enabled lanes take wdata, others keep the old word.
module confreg_sram_byte_merge (
  input  logic [3:0]  wen_i,
  input  logic [31:0] old_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] merged_o
);

  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign merged_o[8*i +: 8] = wen_i[i] ? wdata_i[8*i +: 8] : old_i[8*i +: 8];
  end

endmodule

// File: rtl/confreg_sram.sv
// Confreg responder on the data SRAM port: LED, synchronised switches,
// free-running timer with compare/interrupt, and a scratch register.
module confreg_sram
  import confreg_sram_pkg::*;
#(
  parameter int LED_W = 16,
  parameter int SW_W  = 16,
  parameter int DEC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [3:0]       wen,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic [LED_W-1:0] led,
  input  logic [SW_W-1:0]  switch_in,
  output logic             irq
);

  logic [LED_W-1:0] led_q, led_d;
  logic [SW_W-1:0]  sw1_q, sw2_q;
  logic [31:0]      timer_q, timer_d;
  logic [31:0]      cmp_q, cmp_d;
  logic [31:0]      scr_q, scr_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             ten_q, ten_d, ien_q, ien_d, pend_q, pend_d, irq_q;

  logic [31:0] off, rd_val;
  logic [31:0] led_m, tmr_m, cmp_m, scr_m;
  logic        wr_acc, rd_acc, match, pend_clr;
  logic        unused_bits;

  // Decoded word offset; upper address bits and byte offset are ignored.
  always_comb begin
    off = '0;
    off[DEC_W-1:2] = addr[DEC_W-1:2];
  end

  assign wr_acc = en & (|wen);
  assign rd_acc = en & ~(|wen);

  confreg_sram_byte_merge u_led_m (.wen_i(wen), .old_i(32'(led_q)), .wdata_i(wdata), .merged_o(led_m));
  confreg_sram_byte_merge u_tmr_m (.wen_i(wen), .old_i(timer_q),    .wdata_i(wdata), .merged_o(tmr_m));
  confreg_sram_byte_merge u_cmp_m (.wen_i(wen), .old_i(cmp_q),      .wdata_i(wdata), .merged_o(cmp_m));
  confreg_sram_byte_merge u_scr_m (.wen_i(wen), .old_i(scr_q),      .wdata_i(wdata), .merged_o(scr_m));

  assign unused_bits = ^{addr, led_m};

  // Read mux over pre-edge register state.
  always_comb begin
    rd_val = '0;
    case (off)
      LED_OFF:     rd_val = 32'(led_q);
      SW_OFF:      rd_val = 32'(sw2_q);
      TIMER_OFF:   rd_val = timer_q;
      CMP_OFF:     rd_val = cmp_q;
      CTRL_OFF: begin
        rd_val[CTRL_TEN_BIT]  = ten_q;
        rd_val[CTRL_IEN_BIT]  = ien_q;
        rd_val[CTRL_PEND_BIT] = pend_q;
      end
      SCRATCH_OFF: rd_val = scr_q;
      default:     rd_val = '0;
    endcase
  end

  // Next-state for writes, timer, compare match and rdata hold.
  always_comb begin
    led_d   = led_q;
    cmp_d   = cmp_q;
    scr_d   = scr_q;
    ten_d   = ten_q;
    ien_d   = ien_q;
    rdata_d = rd_acc ? rd_val : rdata_q;
    // A timer write wins over the increment for that cycle.
    if (wr_acc && off == TIMER_OFF) timer_d = tmr_m;
    else if (ten_q)                  timer_d = timer_q + 32'd1;
    else                             timer_d = timer_q;
    if (wr_acc && off == LED_OFF)     led_d = led_m[LED_W-1:0];
    if (wr_acc && off == CMP_OFF)     cmp_d = cmp_m;
    if (wr_acc && off == SCRATCH_OFF) scr_d = scr_m;
    if (wr_acc && off == CTRL_OFF && wen[0]) begin
      ten_d = wdata[CTRL_TEN_BIT];
      ien_d = wdata[CTRL_IEN_BIT];
    end
    pend_clr = wr_acc && off == CTRL_OFF && wen[1] && wdata[CTRL_PEND_BIT];
    match    = ten_q && (timer_q == cmp_q);
    // A match in the same cycle as a W1C keeps pending set.
    pend_d   = match | (pend_q & ~pend_clr);
  end

  // State registers with synchronous reset; irq is registered from next-state.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_q   <= '0;
      sw1_q   <= '0;
      sw2_q   <= '0;
      timer_q <= '0;
      cmp_q   <= CMP_RST;
      scr_q   <= '0;
      ten_q   <= 1'b0;
      ien_q   <= 1'b0;
      pend_q  <= 1'b0;
      irq_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      led_q   <= led_d;
      sw1_q   <= switch_in;
      sw2_q   <= sw1_q;
      timer_q <= timer_d;
      cmp_q   <= cmp_d;
      scr_q   <= scr_d;
      ten_q   <= ten_d;
      ien_q   <= ien_d;
      pend_q  <= pend_d;
      irq_q   <= pend_d & ien_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;
  assign led   = led_q;
  assign irq   = irq_q;

endmodule

// File: tb/tb_confreg_sram.sv
// Self-checking bench for confreg_sram: behavioural model, per-cycle compare,
// directed literal checks, then a randomized phase.
module tb_confreg_sram;
  localparam int LED_W = 16;
  localparam int SW_W  = 16;
  localparam int DEC_W = 8;

  logic             clk = 1'b0;
  logic             rst, en, irq;
  logic [3:0]       wen;
  logic [31:0]      addr, wdata, rdata;
  logic [LED_W-1:0] led;
  logic [SW_W-1:0]  switch_in;

  always #5 clk = ~clk;

  confreg_sram #(.LED_W(LED_W), .SW_W(SW_W), .DEC_W(DEC_W)) dut (
    .clk(clk), .rst(rst), .en(en), .wen(wen), .addr(addr), .wdata(wdata),
    .rdata(rdata), .led(led), .switch_in(switch_in), .irq(irq)
  );

  int checks = 0;
  int failures = 0;
  bit cmp_on = 1'b0;

  // Behavioural model state
  logic [LED_W-1:0] m_led;
  logic [SW_W-1:0]  m_sw1, m_sw2;
  logic [31:0]      m_timer, m_cmp, m_scr, m_rdata;
  logic             m_ten, m_ien, m_pend, m_irq;

  function automatic logic [31:0] lanes(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] w);
    logic [31:0] r = old;
    for (int i = 0; i < 4; i++) if (w[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] o = a & 32'h0000_00FC;
    case (o)
      32'h00: return 32'(m_led);
      32'h04: return 32'(m_sw2);
      32'h08: return m_timer;
      32'h0C: return m_cmp;
      32'h10: return {23'b0, m_pend, 6'b0, m_ien, m_ten};
      32'h14: return m_scr;
      default: return 32'h0;
    endcase
  endfunction

  // One clock edge of the spec'd behaviour, using the inputs present at that edge.
  task automatic model_step();
    logic [31:0] o, t, nt, nc, ns;
    logic [LED_W-1:0] nl;
    logic nten, nien, np, hit, clr;
    if (rst) begin
      m_led = '0; m_sw1 = '0; m_sw2 = '0; m_timer = 0; m_cmp = 32'hFFFF_FFFF;
      m_scr = 0; m_rdata = 0; m_ten = 0; m_ien = 0; m_pend = 0; m_irq = 0;
      return;
    end
    o = addr & 32'h0000_00FC;
    nl = m_led; nc = m_cmp; ns = m_scr; nten = m_ten; nien = m_ien; clr = 1'b0;
    nt = m_ten ? m_timer + 1 : m_timer;
    if (en && wen == 4'h0) m_rdata = m_read(addr);
    if (en && wen != 4'h0) begin
      case (o)
        32'h00: begin t = lanes(32'(m_led), wdata, wen); nl = t[LED_W-1:0]; end
        32'h08: nt = lanes(m_timer, wdata, wen);
        32'h0C: nc = lanes(m_cmp, wdata, wen);
        32'h10: begin
          if (wen[0]) begin nten = wdata[0]; nien = wdata[1]; end
          if (wen[1] && wdata[8]) clr = 1'b1;
        end
        32'h14: ns = lanes(m_scr, wdata, wen);
        default: ;
      endcase
    end
    hit = m_ten && (m_timer == m_cmp);
    np = hit ? 1'b1 : (clr ? 1'b0 : m_pend);
    m_sw2 = m_sw1; m_sw1 = switch_in;
    m_led = nl; m_timer = nt; m_cmp = nc; m_scr = ns;
    m_ten = nten; m_ien = nien; m_pend = np; m_irq = np & nien;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("rdata", rdata, m_rdata);
      chk("led", 32'(led), 32'(m_led));
      chk("irq", {31'b0, irq}, {31'b0, m_irq});
    end
  end

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    en = 1'b0; wen = 4'h0; cyc();
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
    en = 1'b1; wen = w; addr = a; wdata = d; cyc();
  endtask

  task automatic rd(input logic [31:0] a);
    en = 1'b1; wen = 4'h0; addr = a; wdata = $urandom(); cyc();
  endtask

  initial begin
    logic [31:0] offs [9];
    logic [31:0] a;
    offs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'hFC, 32'h40};
    rst = 1'b1; en = 1'b0; wen = 4'h0; addr = 0; wdata = 0; switch_in = '0;
    cyc(); cyc();
    cmp_on = 1'b1;
    rst = 1'b0;

    // Reset values
    rd(32'h00); chk("rst_led", rdata, 32'h0);
    rd(32'h04); chk("rst_sw", rdata, 32'h0);
    rd(32'h08); chk("rst_timer", rdata, 32'h0);
    rd(32'h0C); chk("rst_cmp", rdata, 32'hFFFF_FFFF);
    rd(32'h10); chk("rst_ctrl", rdata, 32'h0);
    rd(32'h14); chk("rst_scr", rdata, 32'h0);
    rd(32'h18); chk("rd_18", rdata, 32'h0);
    rd(32'hFC); chk("rd_fc", rdata, 32'h0);

    // LED byte lanes
    wr(32'h00, 4'h1, 32'hAABB_CCDD); chk("led_l0", 32'(led), 32'h00DD);
    wr(32'h00, 4'h2, 32'h1122_3344); chk("led_l1", 32'(led), 32'h33DD);
    rd(32'h00); chk("led_rd", rdata, 32'h0000_33DD);

    // Timer wrap and write priority
    wr(32'h08, 4'hF, 32'hFFFF_FFFE);
    wr(32'h10, 4'hF, 32'h1);
    idle(); idle(); idle();
    rd(32'h08); chk("tmr_wrap", rdata, 32'h1);
    wr(32'h08, 4'hF, 32'h5);
    rd(32'h08); chk("tmr_wr", rdata, 32'h5);
    rd(32'h08); chk("tmr_inc", rdata, 32'h6);

    // Compare, interrupt, W1C vs set
    wr(32'h10, 4'hF, 32'h0);
    wr(32'h10, 4'hF, 32'h100);
    wr(32'h0C, 4'hF, 32'd10);
    wr(32'h08, 4'hF, 32'd0);
    wr(32'h10, 4'hF, 32'h3);
    repeat (10) idle();
    chk("irq_pre", {31'b0, irq}, 32'h0);
    idle();
    chk("irq_hit", {31'b0, irq}, 32'h1);
    wr(32'h08, 4'hF, 32'd10);
    wr(32'h10, 4'hF, 32'h103);
    chk("w1c_set_wins", {31'b0, irq}, 32'h1);
    wr(32'h10, 4'hF, 32'h103);
    chk("w1c_clear", {31'b0, irq}, 32'h0);
    wr(32'h10, 4'hF, 32'h0);

    // Switch synchroniser latency
    rd(32'h04); rd(32'h04);
    switch_in = 16'hA5A5;
    rd(32'h04); chk("sw_lat1", rdata, 32'h0);
    rd(32'h04); chk("sw_lat2", rdata, 32'h0);
    rd(32'h04); chk("sw_lat3", rdata, 32'h0000_A5A5);

    // Reset during a read
    wr(32'h14, 4'hF, 32'h1234_5678);
    rd(32'h14); chk("scr_rd", rdata, 32'h1234_5678);
    rst = 1'b1; en = 1'b1; wen = 4'h0; addr = 32'h14; cyc();
    chk("rst_mid_rd", rdata, 32'h0);
    rst = 1'b0;
    rd(32'h14); chk("scr_after_rst", rdata, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      a = offs[$urandom_range(0, 8)];
      addr = ($urandom() & 32'hFFFF_FF00) | a | 32'($urandom_range(0, 3));
      en = ($urandom_range(0, 3) != 0);
      wen = ($urandom_range(0, 9) < 5) ? 4'h0 : 4'($urandom_range(1, 15));
      wdata = (a == 32'h08 || a == 32'h0C) && ($urandom_range(0, 1) == 1)
              ? 32'($urandom_range(0, 40)) : $urandom();
      if ($urandom_range(0, 7) == 0) switch_in = SW_W'($urandom());
      rst = ($urandom_range(0, 499) == 0);
      cyc();
    end
    rst = 1'b0; idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
